dram_addr_sequencer: RTL and testbench

//  Controller-side driver for the multiplexed SDRAM address interface: accepts one access request
//  (row/column address + write flag), drives AddrOut/RAS_n/CAS_n/WE_n through activate, column and

---
 rtl/dram_addr_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_dram_addr_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dram_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dram_addr_sequencer
// Purpose  : Runs one SDRAM access per request through ACT, COL and PRE phases,
//            driving the multiplexed address bus and the RAS/CAS/WE strobes.
// Revision : 1.0 - initial release
// ============================================================================
module dram_addr_sequencer #(
    parameter int ROW_W = 8,
    parameter int COL_W = 8,
    parameter int T_RCD = 2,
    parameter int T_CAS = 2,
    parameter int T_RP  = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       req_valid,
    output logic                                       req_ready,
    input  logic [ROW_W-1:0]                           req_row,
    input  logic [COL_W-1:0]                           req_col,
    input  logic                                       req_we,
    output logic [((ROW_W > COL_W) ? ROW_W : COL_W)-1:0] AddrOut,
    output logic                                       RAS_n,
    output logic                                       CAS_n,
    output logic                                       WE_n,
    output logic                                       done
);

    localparam int c_ADDR_W = (ROW_W > COL_W) ? ROW_W : COL_W;

    localparam logic [3:0] c_RCD_LD = 4'(T_RCD - 1);
    localparam logic [3:0] c_CAS_LD = 4'(T_CAS - 1);
    localparam logic [3:0] c_RP_LD  = 4'(T_RP - 1);

    // Counter is 4 bits wide, so every phase length must fit in 1..15.
    if (T_RCD < 1 || T_RCD > 15) begin : g_bad_trcd
        $error("dram_addr_sequencer: T_RCD must be in 1..15");
    end
    if (T_CAS < 1 || T_CAS > 15) begin : g_bad_tcas
        $error("dram_addr_sequencer: T_CAS must be in 1..15");
    end
    if (T_RP < 1 || T_RP > 15) begin : g_bad_trp
        $error("dram_addr_sequencer: T_RP must be in 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACT  = 2'd1,
        ST_COL  = 2'd2,
        ST_PRE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nx;
    logic [COL_W-1:0]    r_col;
    logic                r_we;
    logic                r_req_ready;
    logic [c_ADDR_W-1:0] r_addr;
    logic                r_ras_n;
    logic                r_cas_n;
    logic                r_we_n;
    logic                r_done;

    logic                w_xfer;
    logic                w_req_ready_nx;
    logic [c_ADDR_W-1:0] w_addr_nx;
    logic                w_ras_n_nx;
    logic                w_cas_n_nx;
    logic                w_we_n_nx;
    logic                w_done_nx;

    assign w_xfer = req_valid & r_req_ready;

    // Next state and phase counter; the counter is reloaded on every state entry.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_done_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nx = 4'd0;
                if (w_xfer) begin
                    w_state_nx = ST_ACT;
                    w_cnt_nx   = c_RCD_LD;
                end
            end
            ST_ACT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nx = ST_COL;
                    w_cnt_nx   = c_CAS_LD;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            ST_COL: begin
                if (r_cnt == 4'd0) begin
                    w_state_nx = ST_PRE;
                    w_cnt_nx   = c_RP_LD;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            ST_PRE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = 4'd0;
                    w_done_nx  = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // aligned with the state they belong to.
    always_comb begin
        w_req_ready_nx = 1'b0;
        w_addr_nx      = '0;
        w_ras_n_nx     = 1'b1;
        w_cas_n_nx     = 1'b1;
        w_we_n_nx      = 1'b1;
        case (w_state_nx)
            ST_IDLE: begin
                w_req_ready_nx = 1'b1;
            end
            ST_ACT: begin
                w_ras_n_nx = 1'b0;
                w_addr_nx  = (r_state == ST_IDLE) ? c_ADDR_W'(req_row) : r_addr;
            end
            ST_COL: begin
                w_ras_n_nx = 1'b0;
                w_cas_n_nx = 1'b0;
                w_we_n_nx  = ~r_we;
                w_addr_nx  = c_ADDR_W'(r_col);
            end
            ST_PRE: begin
                w_addr_nx = '0;
            end
            default: begin
                w_req_ready_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_col       <= '0;
            r_we        <= 1'b0;
            r_req_ready <= 1'b0;
            r_addr      <= '0;
            r_ras_n     <= 1'b1;
            r_cas_n     <= 1'b1;
            r_we_n      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_req_ready <= w_req_ready_nx;
            r_addr      <= w_addr_nx;
            r_ras_n     <= w_ras_n_nx;
            r_cas_n     <= w_cas_n_nx;
            r_we_n      <= w_we_n_nx;
            r_done      <= w_done_nx;
            if (w_xfer) begin
                r_col <= req_col;
                r_we  <= req_we;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign AddrOut   = r_addr;
    assign RAS_n     = r_ras_n;
    assign CAS_n     = r_cas_n;
    assign WE_n      = r_we_n;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dram_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_addr_sequencer
// Purpose  : Directed vector table for the default-timing sequencer plus a
//            hand-written sequence for the minimum-timing instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_addr_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-timing instance
    logic       rst_n, valid, we;
    logic [7:0] row, col;
    logic       ready, ras_n, cas_n, we_n, done;
    logic [7:0] addr;

    dram_addr_sequencer u_dut (
        .clk(clk), .reset(rst_n), .req_valid(valid), .req_ready(ready),
        .req_row(row), .req_col(col), .req_we(we), .AddrOut(addr),
        .RAS_n(ras_n), .CAS_n(cas_n), .WE_n(we_n), .done(done)
    );

    // Minimum-timing instance
    logic       rst_f, valid_f, we_f;
    logic [7:0] row_f, col_f;
    logic       ready_f, ras_f, cas_f, wen_f, done_f;
    logic [7:0] addr_f;

    dram_addr_sequencer #(.T_RCD(1), .T_CAS(1), .T_RP(1)) u_dut_fast (
        .clk(clk), .reset(rst_f), .req_valid(valid_f), .req_ready(ready_f),
        .req_row(row_f), .req_col(col_f), .req_we(we_f), .AddrOut(addr_f),
        .RAS_n(ras_f), .CAS_n(cas_f), .WE_n(wen_f), .done(done_f)
    );

    // Column decoder model: captures the bus while CAS_n is low.
    logic [7:0] col_lat = 8'h00;
    always @(posedge clk) if (!cas_f) col_lat <= addr_f;

    typedef struct {
        logic       rn, v;
        logic [7:0] r, c;
        logic       w;
        logic       rdy;
        logic [7:0] a;
        logic       ras, cas, wen, dn;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic rn, input logic v, input logic [7:0] r, input logic [7:0] c,
                       input logic w, input logic rdy, input logic [7:0] a,
                       input logic ras, input logic cas, input logic wen, input logic dn);
        vec_t e;
        e.rn = rn; e.v = v; e.r = r; e.c = c; e.w = w;
        e.rdy = rdy; e.a = a; e.ras = ras; e.cas = cas; e.wen = wen; e.dn = dn;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        rst_n = 0; valid = 0; row = 0; col = 0; we = 0;
        rst_f = 0; valid_f = 0; row_f = 0; col_f = 0; we_f = 0;

        // rn v  row    col    we | rdy addr  ras cas we_n done
        add(0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 1, 1, 1, 0);   // reset held
        add(0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 1, 1, 1, 0);
        add(0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 1, 1, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  1, 8'h00, 1, 1, 1, 0);   // release
        add(1, 1, 8'h12, 8'hAB, 0,  0, 8'h12, 0, 1, 1, 0);   // read transfer
        add(1, 0, 8'hFF, 8'hFF, 1,  0, 8'h12, 0, 1, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'hAB, 0, 0, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'hAB, 0, 0, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'h00, 1, 1, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'h00, 1, 1, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  1, 8'h00, 1, 1, 1, 1);   // done, cycle 7
        add(1, 0, 8'h00, 8'h00, 0,  1, 8'h00, 1, 1, 1, 0);
        add(1, 1, 8'h3C, 8'h55, 1,  0, 8'h3C, 0, 1, 1, 0);   // write transfer
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'h3C, 0, 1, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'h55, 0, 0, 0, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'h55, 0, 0, 0, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'h00, 1, 1, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'h00, 1, 1, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  1, 8'h00, 1, 1, 1, 1);
        add(1, 1, 8'h01, 8'h02, 0,  0, 8'h01, 0, 1, 1, 0);   // accepted in done cycle
        add(1, 1, 8'h77, 8'h77, 1,  0, 8'h01, 0, 1, 1, 0);   // valid held, not ready
        add(1, 1, 8'h77, 8'h77, 1,  0, 8'h02, 0, 0, 1, 0);
        add(1, 1, 8'h77, 8'h77, 1,  0, 8'h02, 0, 0, 1, 0);
        add(1, 1, 8'h77, 8'h77, 1,  0, 8'h00, 1, 1, 1, 0);
        add(1, 1, 8'h77, 8'h77, 1,  0, 8'h00, 1, 1, 1, 0);
        add(1, 1, 8'h33, 8'h44, 1,  1, 8'h00, 1, 1, 1, 1);
        add(1, 1, 8'h33, 8'h44, 1,  0, 8'h33, 0, 1, 1, 0);   // second request, period 7
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'h33, 0, 1, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'h44, 0, 0, 0, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'h44, 0, 0, 0, 0);   // second CAS cycle
        add(0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 1, 1, 1, 0);   // reset mid-COL
        add(1, 1, 8'hEE, 8'hEE, 1,  1, 8'h00, 1, 1, 1, 0);   // valid while not ready
        add(1, 0, 8'h00, 8'h00, 0,  1, 8'h00, 1, 1, 1, 0);
        add(1, 1, 8'h5A, 8'hA5, 0,  0, 8'h5A, 0, 1, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'h5A, 0, 1, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'hA5, 0, 0, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'hA5, 0, 0, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'h00, 1, 1, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  0, 8'h00, 1, 1, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0,  1, 8'h00, 1, 1, 1, 1);
        add(1, 0, 8'h00, 8'h00, 0,  1, 8'h00, 1, 1, 1, 0);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rn; valid = vecs[i].v; row = vecs[i].r;
            col = vecs[i].c; we = vecs[i].w;
            step();
            total++;
            if ({ready, addr, ras_n, cas_n, we_n, done} !==
                {vecs[i].rdy, vecs[i].a, vecs[i].ras, vecs[i].cas, vecs[i].wen, vecs[i].dn}) begin
                bad++;
                $display("FAIL vec%0d: got rdy=%b addr=%h ras=%b cas=%b we_n=%b done=%b expected rdy=%b addr=%h ras=%b cas=%b we_n=%b done=%b",
                         i, ready, addr, ras_n, cas_n, we_n, done, vecs[i].rdy, vecs[i].a,
                         vecs[i].ras, vecs[i].cas, vecs[i].wen, vecs[i].dn);
            end
        end

        // Minimum timing: one cycle per phase, done 4 cycles after transfer.
        rst_f = 1;
        step();
        chk("fast_ready_after_release", {7'd0, ready_f}, 8'h01);
        valid_f = 1; row_f = 8'h12; col_f = 8'hAB; we_f = 0;
        step();
        valid_f = 0; row_f = 8'h00; col_f = 8'h00;
        cyc = 1;
        chk("fast_act_strobes", {6'd0, ras_f, cas_f}, 8'h01);
        chk("fast_act_addr", addr_f, 8'h12);
        step(); cyc++;
        chk("fast_col_strobes", {5'd0, ras_f, cas_f, wen_f}, 8'h01);
        chk("fast_col_addr", addr_f, 8'hAB);
        step(); cyc++;
        chk("fast_pre_strobes", {5'd0, ras_f, cas_f, done_f}, 8'h06);
        chk("fast_pre_addr", addr_f, 8'h00);
        while (!done_f && cyc < 20) begin
            step(); cyc++;
        end
        chk("fast_done_latency", 8'(cyc), 8'd4);
        chk("fast_done_ready", {7'd0, ready_f}, 8'h01);
        chk("fast_col_latched", col_lat, 8'hAB);
        step();
        chk("fast_done_single_pulse", {7'd0, done_f}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
